// File: rtl/inst_fetch_mem.sv
// Byte-preloadable instruction memory with a fixed-latency, stallable fetch pipeline.
// Responses carry the request address plus misalignment / out-of-range error flags.
module inst_fetch_mem #(
    parameter int unsigned DEPTH_BYTES = 256,
    parameter int unsigned LAT         = 2,
    parameter int unsigned BIG_ENDIAN  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    output logic        req_ready,
    input  logic        stall,
    input  logic        ld_en,
    input  logic [31:0] ld_addr,
    input  logic [7:0]  ld_data,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic [31:0] rsp_addr,
    output logic [1:0]  rsp_err,
    output logic [15:0] fetch_cnt
);

    localparam int unsigned AW        = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
    localparam logic [31:0] LAST_WORD = 32'(DEPTH_BYTES - 4);

    logic [7:0]    mem_q [DEPTH_BYTES];
    logic          mem_we;
    logic [AW-1:0] mem_widx;

    logic          accept;
    logic [1:0]    rd_err;
    logic [AW-1:0] rd_base;
    logic [7:0]    rd_b0, rd_b1, rd_b2, rd_b3;
    logic [31:0]   rd_word;

    logic          v_q    [LAT];
    logic          v_d    [LAT];
    logic [31:0]   data_q [LAT];
    logic [31:0]   data_d [LAT];
    logic [31:0]   addr_q [LAT];
    logic [31:0]   addr_d [LAT];
    logic [1:0]    err_q  [LAT];
    logic [1:0]    err_d  [LAT];

    logic [15:0]   cnt_q;
    logic [15:0]   cnt_d;

    always_comb begin
        req_ready = !stall && !ld_en && !reset;
        accept    = req_valid && req_ready;
    end

    // Preload port; writes also land while in reset or stalled.
    always_comb begin
        mem_we   = ld_en && (ld_addr < 32'(DEPTH_BYTES));
        mem_widx = ld_addr[AW-1:0];
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_widx] <= ld_data;
        end
    end

    // Errored fetches read from index 0 so the array is never addressed past its end.
    always_comb begin
        rd_err[0] = (req_addr[1:0] != 2'b00);
        rd_err[1] = (req_addr > LAST_WORD);
        rd_base   = (rd_err == 2'b00) ? req_addr[AW-1:0] : '0;
        rd_b0     = mem_q[rd_base];
        rd_b1     = mem_q[rd_base + AW'(1)];
        rd_b2     = mem_q[rd_base + AW'(2)];
        rd_b3     = mem_q[rd_base + AW'(3)];
        if (rd_err != 2'b00) begin
            rd_word = '0;
        end else if (BIG_ENDIAN != 0) begin
            rd_word = {rd_b0, rd_b1, rd_b2, rd_b3};
        end else begin
            rd_word = {rd_b3, rd_b2, rd_b1, rd_b0};
        end
    end

    // Empty stages carry all-zero payload so the outputs read 0 whenever invalid.
    always_comb begin
        v_d    = v_q;
        data_d = data_q;
        addr_d = addr_q;
        err_d  = err_q;
        if (reset) begin
            for (int unsigned i = 0; i < LAT; i++) begin
                v_d[i]    = 1'b0;
                data_d[i] = '0;
                addr_d[i] = '0;
                err_d[i]  = '0;
            end
        end else if (!stall) begin
            v_d[0]    = accept;
            data_d[0] = accept ? rd_word  : '0;
            addr_d[0] = accept ? req_addr : '0;
            err_d[0]  = accept ? rd_err   : '0;
            for (int unsigned i = 1; i < LAT; i++) begin
                v_d[i]    = v_q[i-1];
                data_d[i] = data_q[i-1];
                addr_d[i] = addr_q[i-1];
                err_d[i]  = err_q[i-1];
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (reset) begin
            cnt_d = '0;
        end else if (accept && (cnt_q != '1)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        v_q    <= v_d;
        data_q <= data_d;
        addr_q <= addr_d;
        err_q  <= err_d;
        cnt_q  <= cnt_d;
    end

    always_comb begin
        rsp_valid = v_q[LAT-1] && !reset;
        rsp_data  = rsp_valid ? data_q[LAT-1] : '0;
        rsp_addr  = rsp_valid ? addr_q[LAT-1] : '0;
        rsp_err   = rsp_valid ? err_q[LAT-1]  : '0;
        fetch_cnt = cnt_q;
    end

endmodule

// File: doc/inst_fetch_mem.md
INST_FETCH_MEM -- requirements
Module: inst_fetch_mem

Interface
REQ-001 Parameter DEPTH_BYTES, 256: byte capacity of the instruction array; legal range 8..65536, multiple of 4.
REQ-002 Parameter LAT, 2: request-to-response latency in unstalled cycles; legal range 1..4.
REQ-003 Parameter BIG_ENDIAN, 1: 1 = byte at addr is rsp_data[31:24]; 0 = byte at addr is rsp_data[7:0].
REQ-004 Clock and reset: one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  clock; all state updates on the rising edge.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 req_valid  input  1  fetch request present.
REQ-008 req_addr  input  32  byte address of the fetch.
REQ-009 req_ready  output  1  request is accepted this cycle if req_valid is high.
REQ-010 stall  input  1  freezes the response pipeline.
REQ-011 ld_en  input  1  preload byte write strobe.
REQ-012 ld_addr  input  32  preload byte address.
REQ-013 ld_data  input  8  preload byte.
REQ-014 rsp_valid  output  1  response present.
REQ-015 rsp_data  output  32  fetched instruction word.
REQ-016 rsp_addr  output  32  req_addr of the request being answered.
REQ-017 rsp_err  output  2  bit0 = misaligned; bit1 = out of range.
REQ-018 fetch_cnt  output  16  count of accepted requests; saturates at 16'hFFFF.

Function
REQ-019 req_ready SHALL be !stall && !ld_en && !reset (combinational).
REQ-020 Accept condition: req_valid && req_ready at a rising edge; the word SHALL be read from the array at that edge into pipeline stage 1.
REQ-021 Pipeline: LAT stages, each with valid, data, addr, and err fields; rsp_* SHALL be driven from stage LAT; with no stall, a response SHALL appear exactly LAT cycles after acceptance.
REQ-022 Back-to-back accepts SHALL be supported: one response per cycle, in request order, none dropped or duplicated.
REQ-023 While stall is high, all stages SHALL hold their contents and rsp_* SHALL stay constant; no new request is accepted.
REQ-024 A stage with no accepted request SHALL carry valid=0; while rsp_valid is 0, rsp_data, rsp_addr and rsp_err SHALL be 0.
REQ-025 Word assembly, BIG_ENDIAN=1: {M[a],M[a+1],M[a+2],M[a+3]}.
REQ-026 Word assembly, BIG_ENDIAN=0: {M[a+3],M[a+2],M[a+1],M[a]}.
REQ-027 Misaligned request (req_addr[1:0] != 0): the response SHALL have rsp_err[0]=1 and rsp_data=0.
REQ-028 Out-of-range request (req_addr > DEPTH_BYTES-4, unsigned 32-bit compare): the response SHALL have rsp_err[1]=1 and rsp_data=0.
REQ-029 Both error bits may be set together; the address SHALL never wrap and the array SHALL never be read out of range.
REQ-030 Preload: when ld_en=1 and ld_addr < DEPTH_BYTES, M[ld_addr] <= ld_data; an out-of-range ld_addr SHALL be ignored silently.
REQ-031 Preload is allowed while stall is high; in-flight stages SHALL be unaffected.
REQ-032 A request accepted in the cycle after a preload write SHALL observe the new byte.
REQ-033 fetch_cnt SHALL increment by 1 per accept, including errored requests, and SHALL hold at 16'hFFFF.

Reset
REQ-034 When reset=1 at a rising edge, all stage valids SHALL clear and fetch_cnt SHALL be set to 0.
REQ-035 During reset, rsp_valid=0, rsp_data=0, rsp_addr=0, rsp_err=0, and req_ready=0.
REQ-036 Array contents SHALL NOT be altered by reset.
REQ-037 Requests in flight at reset SHALL be discarded and SHALL never produce a response.
REQ-038 ld_en asserted during reset SHALL still write.

Verification
REQ-039 Preload bytes 0..7 = E3,A0,00,01,E2,81,10,02; accept addr 0 then addr 4 on consecutive cycles (LAT=2) -> rsp_data E3A00001 at accept+2 and E2811002 at accept+3, rsp_err=0, fetch_cnt=2.
REQ-040 Same preload with BIG_ENDIAN=0; fetch addr 0 -> rsp_data 0100A0E3.
REQ-041 Fetch addr 2 -> rsp_err=01, rsp_data=0; fetch addr 253 (DEPTH_BYTES=256) -> rsp_err=11; fetch addr 252 -> rsp_err=00.
REQ-042 Accept 3 back-to-back requests; hold stall high for 3 cycles after the first accept -> rsp_* frozen, req_ready=0 throughout the stall, all 3 responses delivered in order after stall drops.
REQ-043 Assert reset with 2 requests in flight -> rsp_valid=0 on the following cycle, no response for either request, fetch_cnt=0, preloaded bytes intact on refetch.
REQ-044 Drive 65537 accepts -> fetch_cnt=FFFF; ld_en high together with req_valid -> req_ready=0 and the byte is written.
